bram_rd_streamer: RTL and testbench

//  Read-side client for the team's byte-write true-dual-port block RAM: walks one BRAM port

---
 rtl/bram_rd_streamer.sv | 196 +++++++++++++++++++
 tb/tb_bram_rd_streamer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: walks one BRAM read port over a word range and
// turns its fixed read latency into a valid/ready stream.
module bram_rd_streamer #(
  parameter  int WIDTH        = 128,
  parameter  int DEPTH        = 2048,
  parameter  int READ_LATENCY = 2,
  parameter  int LEN_W        = 12,
  parameter  int FIFO_DEPTH   = 4,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  base_addr_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ADDR_W-1:0]  bram_addr_o,
  output logic               bram_en_o,
  output logic [WIDTH/8-1:0] bram_we_o,
  output logic               bram_oreg_en_o,
  output logic               bram_rst_o,
  input  logic [WIDTH-1:0]   bram_dout_i,
  output logic [WIDTH-1:0]   m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               m_last_o
);

  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = ((IW > CW) ? IW : CW) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    ABORT
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [IW-1:0]      inf_q;
  logic [READ_LATENCY-1:0] pv_q;
  logic [READ_LATENCY-1:0] pl_q;

  logic [WIDTH-1:0]   fd_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fl_q;
  logic [PW-1:0]      wr_q;
  logic [PW-1:0]      rd_q;
  logic [CW-1:0]      cnt_q;

  logic               pop;
  logic               ret;
  logic               push;
  logic               abort_go;
  logic               issue;
  logic               issue_last;
  logic [OW-1:0]      occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bram_we_o      = '0;
  assign bram_oreg_en_o = 1'b1;
  assign bram_rst_o     = 1'b0;

  assign m_valid_o = (cnt_q != '0);
  assign m_data_o  = fd_q[rd_q];
  assign m_last_o  = m_valid_o & fl_q[rd_q];

  // Credit check and issue decision; a beat popped this cycle frees its slot.
  always_comb begin
    pop        = m_valid_o & m_ready_i;
    ret        = pv_q[READ_LATENCY-1];
    abort_go   = abort_i & ((state_q == RUN) | (state_q == DRAIN));
    push       = ret & (state_q != ABORT) & ~abort_go;
    occ        = OW'(inf_q) + OW'(cnt_q) - OW'(pop);
    issue      = (state_q == RUN) & ~abort_i & (occ < OW'(FIFO_DEPTH));
    issue_last = issue & (rem_q == LEN_W'(1));
  end

  assign bram_en_o   = issue;
  assign bram_addr_o = addr_q;

  // Valid/last tags travelling alongside the BRAM read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv_q  <= '0;
      pl_q  <= '0;
      inf_q <= '0;
    end else begin
      pv_q[0] <= issue;
      pl_q[0] <= issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
      inf_q <= inf_q + IW'(issue) - IW'(ret);
    end
  end

  // Output skid FIFO; an abort drops every word not yet accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fd_q[i] <= '0;
      end
      fl_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (abort_go) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fd_q[wr_q] <= bram_dout_i;
        fl_q[wr_q] <= pl_q[READ_LATENCY-1];
        wr_q       <= ptr_inc(wr_q);
      end
      if (pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Transfer control: address walk, remaining count, busy/done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_o  <= 1'b1;
              addr_q  <= base_addr_i;
              rem_q   <= len_i;
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q <= ABORT;
          end else if (issue) begin
            addr_q <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (issue_last) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort_i) begin
            state_q <= ABORT;
          end else if (inf_q == '0 &&
                       (cnt_q == '0 || (cnt_q == CW'(1) && pop))) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        ABORT: begin
          if (inf_q == '0) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The credit rule must keep a push from landing on a full FIFO.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn)
    !(push && !pop && cnt_q == CW'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_bram_rd_streamer.sv
// tb_bram_rd_streamer: vector table plus hand sequences for
// bram_rd_streamer against a queue-based stream model.
module tb_bram_rd_streamer;

  localparam int WIDTH = 128;
  localparam int DEPTH = 2048;
  localparam int RL    = 2;
  localparam int LEN_W = 12;
  localparam int FD    = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rstn;
  logic             start_i;
  logic [AW-1:0]    base_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic [AW-1:0]    bram_addr_o;
  logic             bram_en_o;
  logic [WIDTH/8-1:0] bram_we_o;
  logic             bram_oreg_en_o;
  logic             bram_rst_o;
  logic [WIDTH-1:0] bram_dout_i;
  logic [WIDTH-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic             m_last_o;

  bram_rd_streamer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .READ_LATENCY(RL),
    .LEN_W(LEN_W), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o),
    .bram_addr_o(bram_addr_o), .bram_en_o(bram_en_o),
    .bram_we_o(bram_we_o), .bram_oreg_en_o(bram_oreg_en_o),
    .bram_rst_o(bram_rst_o), .bram_dout_i(bram_dout_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_last_o(m_last_o)
  );

  typedef struct {
    int base;
    int len;
    int pct;
    int exp_beats;
    int exp_done_lat;
  } vec_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] expq [$];
  int               explast [$];
  int               addr_log [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_pct = 100;
  int issued, accepted, beat_cnt, valid_seen, ovf;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_valid_cyc, last_beat_cyc, start_cyc;
  logic en_s;
  logic [AW-1:0] addr_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port model: two-stage read latency, inputs captured mid-cycle.
  always @(negedge clk) begin
    en_s   = bram_en_o;
    addr_s = bram_addr_o;
  end
  always @(posedge clk) begin
    if (en_s) s1 <= mem[addr_s];
    s2 <= s1;
  end
  assign bram_dout_i = s2;

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream monitor: every accepted beat is checked against the model queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (bram_en_o) begin
        issued++;
        addr_log.push_back(int'(bram_addr_o));
      end
      if (m_valid_o) begin
        valid_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (m_valid_o && m_ready_i) begin
        accepted++;
        beat_cnt++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0h expected none", m_data_o);
        end else begin
          chk_w("beat_data", m_data_o, expq.pop_front());
          chk_i("beat_last", int'(m_last_o), explast.pop_front());
        end
        if (m_last_o) last_beat_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (issued - accepted > FD) ovf++;
    end
  end

  // Random backpressure.
  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = (int'($urandom_range(99)) < ready_pct);
    end
  end

  task automatic start_xfer(input int base, input int len);
    @(posedge clk);
    #1;
    expq.delete();
    explast.delete();
    addr_log.delete();
    for (int i = 0; i < len; i++) begin
      expq.push_back(mem[(base + i) % DEPTH]);
      explast.push_back((i == len - 1) ? 1 : 0);
    end
    issued = 0; accepted = 0; beat_cnt = 0; valid_seen = 0; ovf = 0;
    first_valid_cyc = -1;
    last_beat_cyc = -1;
    start_i = 1'b1;
    base_addr_i = AW'(base);
    len_i = LEN_W'(len);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    chk_i("done_seen", (done_cnt != d0) ? 1 : 0, 1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && beat_cnt < n; i++) @(posedge clk);
    chk_i("beats_reached", (beat_cnt >= n) ? 1 : 0, 1);
  endtask

  initial begin
    vec_t vecs [5];
    int   wexp [4];
    int   d0, a, viol;

    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
    wexp[0] = 0;
    vecs[0] = '{0, 0, 0, 0, 0};
    d0 = 0; a = 0; viol = 0;
  end

  initial begin
    vec_t vecs [5];
    int   wexp [4];
    int   d0, a, viol;

    for (int i = 0; i < DEPTH; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{32'h123, 16, 50, 16, -1};
    vecs[1] = '{int'($urandom_range(DEPTH-1)), 1, 100, 1, 5};
    vecs[2] = '{32'h7FD, 7, 30, 7, -1};
    vecs[3] = '{int'($urandom_range(DEPTH-1)), 20, 100, 20, 24};
    vecs[4] = '{int'($urandom_range(DEPTH-1)), 5, 75, 5, -1};
    wexp = '{32'h7FE, 32'h7FF, 0, 1};

    rstn = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    base_addr_i = '0; len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk_i("rst_ctrl", int'({busy_o, done_o, bram_en_o, m_valid_o, m_last_o}), 0);
    chk_i("rst_addr", int'(bram_addr_o), 0);
    chk_i("rst_tie", int'({bram_we_o, bram_oreg_en_o, bram_rst_o}), 2);
    chk_w("rst_data", m_data_o, '0);

    // Basic transfer with latency and done timing.
    ready_pct = 100;
    d0 = done_cnt;
    start_xfer(32'h010, 8);
    chk_i("t1_busy", int'(busy_o), 1);
    wait_done(d0, 100);
    repeat (2) @(posedge clk);
    chk_i("t1_first_valid", first_valid_cyc - start_cyc, RL + 2);
    chk_i("t1_last_beat", last_beat_cyc - start_cyc, RL + 2 + 7);
    chk_i("t1_done", done_cyc - start_cyc, RL + 2 + 8);
    chk_i("t1_beats", beat_cnt, 8);
    chk_i("t1_busy_end", int'(busy_o), 0);

    // Address wrap.
    d0 = done_cnt;
    start_xfer(32'h7FE, 4);
    wait_done(d0, 100);
    repeat (2) @(posedge clk);
    chk_i("t2_naddr", addr_log.size(), 4);
    if (addr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk_i("t2_addr", addr_log[i], wexp[i]);
    chk_i("t2_beats", beat_cnt, 4);

    // Vector table, randomized backpressure.
    for (int r = 0; r < 5; r++) begin
      ready_pct = vecs[r].pct;
      d0 = done_cnt;
      start_xfer(vecs[r].base, vecs[r].len);
      wait_done(d0, 40 * vecs[r].len + 50);
      repeat (2) @(posedge clk);
      chk_i("row_beats", beat_cnt, vecs[r].exp_beats);
      chk_i("row_done_once", done_cnt - d0, 1);
      chk_i("row_fifo_bound", ovf, 0);
      if (vecs[r].exp_done_lat >= 0)
        chk_i("row_done_lat", done_cyc - start_cyc, vecs[r].exp_done_lat);
    end

    // Empty transfer.
    ready_pct = 100;
    d0 = done_cnt;
    start_xfer(5, 0);
    repeat (3) @(posedge clk);
    chk_i("t4_done_cnt", done_cnt - d0, 1);
    chk_i("t4_done_lat", done_cyc - start_cyc, 1);
    chk_i("t4_no_en", issued, 0);
    chk_i("t4_no_valid", valid_seen, 0);
    chk_i("t4_busy", int'(busy_o), 0);

    // Abort after five beats.
    d0 = done_cnt;
    start_xfer(32'h200, 32);
    wait_beats(5, 60);
    #1;
    abort_i = 1'b1;
    a = cyc;
    @(negedge clk);
    chk_i("t5_abort_no_issue", int'(bram_en_o), 0);
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_valid_o) viol++;
    end
    chk_i("t5_valid_low", viol, 0);
    chk_i("t5_done_once", done_cnt - d0, 1);
    chk_i("t5_done_lat_ok",
          (done_cyc > a && done_cyc - a <= RL + 1) ? 1 : 0, 1);
    chk_i("t5_busy", int'(busy_o), 0);
    expq.delete();
    explast.delete();
    d0 = done_cnt;
    start_xfer(32'h300, 3);
    wait_done(d0, 100);
    repeat (2) @(posedge clk);
    chk_i("t5_restart_beats", beat_cnt, 3);

    // Reset in the middle of a transfer.
    d0 = done_cnt;
    start_xfer(32'h040, 8);
    wait_beats(3, 60);
    #1;
    rstn = 1'b0;
    #1;
    chk_i("t6_ctrl", int'({busy_o, done_o, bram_en_o, m_valid_o, m_last_o}), 0);
    chk_i("t6_addr", int'(bram_addr_o), 0);
    chk_w("t6_data", m_data_o, '0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    chk_i("t6_no_done", done_cnt - d0, 0);
    expq.delete();
    explast.delete();
    d0 = done_cnt;
    start_xfer(32'h055, 2);
    wait_done(d0, 100);
    repeat (2) @(posedge clk);
    chk_i("t6_restart_beats", beat_cnt, 2);
    chk_i("t6_model_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
